// File: rtl/regfile_mp.sv
// Multi-port integer register file with x0 hardwired to zero and a per-register pending scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 sb_set_en,
    input  logic [AW-1:0]        sb_set_addr,
    output logic                 any_busy
);

    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_mp: NREGS must be a power of 2 and at least 2");
    end
    if (NRD < 1) begin : g_bad_nrd
        $error("regfile_mp: NRD must be at least 1");
    end
    if (NWR < 1) begin : g_bad_nwr
        $error("regfile_mp: NWR must be at least 1");
    end

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;

    // NOTE: the array is built from flops, not a RAM macro, so resetting every
    // entry is legal and gives software a known all-zero register state.
    // NOTE: ports are visited in ascending order and the last non-blocking
    // assignment to an entry wins, which makes the highest-index port win a conflict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    // Completed writes clear first, then a new producer sets, so set wins on a collision.
    // NOTE: every output of an always_comb starts from a default so no latch is inferred.
    always_comb begin
        pending_next = pending;
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0) begin
                pending_next[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en && sb_set_addr != '0) begin
            pending_next[sb_set_addr] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign any_busy = |pending;

    // Busy reflects registered state only; forwarding never touches it.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_addr[i*AW +: AW] != '0) begin
                rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                rd_busy[i]              = pending[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (rst_n) begin
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW]) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                        end
                    end
                end
`else
                // Without forwarding a write becomes visible one cycle later.
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp in its default configuration (2 read, 2 write ports);
// expected read-during-write results follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                sb_set_en;
    logic [AW-1:0]       sb_set_addr;
    logic                any_busy;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .sb_set_en  (sb_set_en),
        .sb_set_addr(sb_set_addr),
        .any_busy   (any_busy)
    );

    always #5 clk = ~clk;

    // Commit one clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;
    endtask

    task automatic drive_wr(input int port, input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        wr_en[port]              = 1'b1;
        wr_addr[port*AW +: AW]   = addr;
        wr_data[port*XLEN +: XLEN] = data;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        rst_n = 1'b0;
        idle_inputs();
        rd_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < NREGS; k++) begin
            a = AW'(k);
            b = AW'(NREGS - 1 - k);
            set_rd(a, b);
            n_cmp++;
            if (rd_data !== '0 || rd_busy !== '0 || any_busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_read addr=%0d: data=%h busy=%b any=%b, want data=0 busy=0 any=0",
                         k, rd_data, rd_busy, any_busy);
            end
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        drive_wr(0, 5'd0, 32'hDEAD_BEEF);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd0;
        set_rd(5'd0, 5'd0);
        n_cmp++;
        if (rd_data !== '0) begin
            n_err++;
            $display("FAIL x0_same_cycle: data=%h, want 0", rd_data);
        end
        tick();
        idle_inputs();
        set_rd(5'd0, 5'd0);
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL x0_read: data=%h busy=%b, want 0/0", rd_data, rd_busy);
        end
        n_cmp++;
        if (any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL x0_any_busy: got %b, want 0", any_busy);
        end
    endtask

    task automatic test_conflict();
        idle_inputs();
        drive_wr(0, 5'd5, 32'h1111_1111);
        drive_wr(1, 5'd5, 32'h2222_2222);
        tick();
        idle_inputs();
        drive_wr(0, 5'd6, 32'h0000_000A);
        drive_wr(1, 5'd7, 32'h0000_000B);
        tick();
        idle_inputs();
        set_rd(5'd5, 5'd6);
        n_cmp++;
        if (rd_data[31:0] !== 32'h2222_2222) begin
            n_err++;
            $display("FAIL conflict_x5: got %h, want 22222222", rd_data[31:0]);
        end
        n_cmp++;
        if (rd_data[63:32] !== 32'h0000_000A) begin
            n_err++;
            $display("FAIL dual_x6: got %h, want 0000000a", rd_data[63:32]);
        end
        set_rd(5'd7, 5'd5);
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_000B) begin
            n_err++;
            $display("FAIL dual_x7: got %h, want 0000000b", rd_data[31:0]);
        end
        n_cmp++;
        if (rd_data[63:32] !== 32'h2222_2222) begin
            n_err++;
            $display("FAIL conflict_x5_port1: got %h, want 22222222", rd_data[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd9);
        n_cmp++;
        if (rd_busy !== 2'b11 || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_set: busy=%b any=%b, want 11/1", rd_busy, any_busy);
        end
        set_rd(5'd8, 5'd9);
        n_cmp++;
        if (rd_busy !== 2'b10) begin
            n_err++;
            $display("FAIL sb_other_reg: busy=%b, want 10", rd_busy);
        end
        drive_wr(0, 5'd9, 32'h0000_0055);
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd0);
        n_cmp++;
        if (rd_busy[0] !== 1'b0 || rd_data[31:0] !== 32'h0000_0055 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_clear: busy=%b data=%h any=%b, want 0/00000055/0",
                     rd_busy[0], rd_data[31:0], any_busy);
        end
        drive_wr(1, 5'd9, 32'h0000_0066);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd9;
        tick();
        idle_inputs();
        set_rd(5'd9, 5'd0);
        n_cmp++;
        if (rd_busy[0] !== 1'b1 || rd_data[31:0] !== 32'h0000_0066 || any_busy !== 1'b1) begin
            n_err++;
            $display("FAIL sb_set_wins: busy=%b data=%h any=%b, want 1/00000066/1",
                     rd_busy[0], rd_data[31:0], any_busy);
        end
        drive_wr(0, 5'd9, 32'h0000_0066);
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL sb_final_clear: any=%b, want 0", any_busy);
        end
    endtask

    task automatic test_read_during_write();
        logic [XLEN-1:0] exp_same;
        idle_inputs();
        drive_wr(0, 5'd3, 32'h0000_0100);
        tick();
        idle_inputs();
        drive_wr(0, 5'd3, 32'h0000_0200);
        set_rd(5'd3, 5'd3);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h0000_0200;
`else
        exp_same = 32'h0000_0100;
`endif
        n_cmp++;
        if (rd_data[31:0] !== exp_same || rd_data[63:32] !== exp_same || rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL rdw_same_cycle: data=%h busy=%b, want %h on both ports busy=00",
                     rd_data, rd_busy, exp_same);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL rdw_next_cycle: got %h, want 00000200", rd_data[31:0]);
        end
        // Two ports writing the read address: forwarding must pick port 1.
        drive_wr(0, 5'd3, 32'h0000_0300);
        drive_wr(1, 5'd3, 32'h0000_0400);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h0000_0400;
`else
        exp_same = 32'h0000_0200;
`endif
        n_cmp++;
        if (rd_data[31:0] !== exp_same) begin
            n_err++;
            $display("FAIL rdw_conflict_same_cycle: got %h, want %h", rd_data[31:0], exp_same);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_0400) begin
            n_err++;
            $display("FAIL rdw_conflict_next_cycle: got %h, want 00000400", rd_data[31:0]);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        drive_wr(0, 5'd4, 32'h0000_0044);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd10;
        tick();
        idle_inputs();
        rst_n = 1'b0;
        drive_wr(1, 5'd4, 32'h0000_0077);
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        set_rd(5'd4, 5'd10);
        n_cmp++;
        if (rd_data[31:0] !== 32'h0000_0044 || rd_busy[1] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_edge: data=%h busy10=%b, want 00000044/1",
                     rd_data[31:0], rd_busy[1]);
        end
        tick();
        idle_inputs();
        rst_n = 1'b1;
        tick();
        set_rd(5'd4, 5'd5);
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0 || any_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: data=%h busy=%b any=%b, want 0/00/0",
                     rd_data, rd_busy, any_busy);
        end
        set_rd(5'd10, 5'd3);
        n_cmp++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            n_err++;
            $display("FAIL reset_mid_others: data=%h busy=%b, want 0/00", rd_data, rd_busy);
        end
    endtask

    initial begin
        test_reset();
        test_x0();
        test_conflict();
        test_scoreboard();
        test_read_during_write();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV32I core family and its wider/superscalar successors. It provides NRD asynchronous read ports and NWR synchronous write ports, with x0 hardwired to zero. A per-register pending scoreboard tracks in-flight producers for hazard detection. Optional write-to-read bypass supports same-cycle forwarding.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >=2); register 0 is hardwired to zero
NRD, 2, number of read ports (1..8)
NWR, 2, number of write ports (1..4)
AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
rd_addr  in  NRD*AW  read addresses; port i is at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data; port i is at [i*XLEN +: XLEN]
rd_busy  out  NRD  pending bit of the register addressed by read port i
wr_en  in  NWR  write enable for each write port
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
sb_set_en  in  1  mark register sb_set_addr as pending (producer issued)
sb_set_addr  in  AW  scoreboard set address
any_busy  out  1  OR of all pending bits

Behaviour:
- Reset: while rst_n=0 at a clk edge, all registers are set to 0 and all pending bits to 0. Writes and sb_set in the same cycle are ignored. Reads are combinational, so during reset rd_data shows the current contents (0 after the first reset edge), and rd_busy and any_busy are 0 after that edge.
- Reads: combinational with zero latency. rd_data[i] = 0 and rd_busy[i] = 0 whenever rd_addr[i] == 0. Any number of ports may read the same address.
- Writes: on posedge clk, when wr_en[j]=1 and wr_addr[j]!=0, the register takes wr_data[j]. Writes to address 0 are discarded.
- Write conflict: if several enabled ports target the same address, the highest-index port wins and the others are dropped silently.
- Scoreboard:
  - An enabled write with a non-zero address clears the pending bit of that register at the clk edge.
  - sb_set_en=1 with sb_set_addr!=0 sets the pending bit. sb_set_addr=0 has no effect.
  - If a set and a clear hit the same register in the same cycle, set wins (the new producer supersedes the completed one). The data write still happens.
  - rd_busy reflects only registered state. It is not bypassed.
- Read-during-write without bypass: rd_data returns the old value in that cycle and the new value from the next cycle.
- No internal state machine beyond the storage and pending arrays. There is no handshake: writes are always accepted.
- Elaboration: NREGS not a power of 2, NRD=0, or NWR=0 raises $error.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if read address i is non-zero and equals the address of an enabled write port in the same cycle, rd_data[i] returns that wr_data combinationally. The highest-index matching port wins, consistent with the conflict rule. rd_busy is unaffected. Bypass is suppressed while rst_n=0.
- Undefined: reads return stored contents only, with the one-cycle visibility delay described above.

Test Plan:
- Reset then read: hold rst_n=0 for 2 cycles, release, read all addresses 0..NREGS-1 -> every rd_data=0, rd_busy=0, any_busy=0.
- x0 immunity: write port 0 addr 0 data 0xDEADBEEF, sb_set addr 0 -> reading addr 0 gives 0 and rd_busy=0; any_busy stays 0.
- Dual-write conflict: port0 writes x5=0x11111111 and port1 writes x5=0x22222222 in the same cycle; also port0 x6=0xA, port1 x7=0xB on the next cycle -> x5=0x22222222, x6=0xA, x7=0xB.
- Scoreboard: sb_set x9, next cycle read x9 -> rd_busy=1, any_busy=1. Write x9=0x55 -> next cycle rd_busy=0, rd_data=0x55. Set and write x9 in the same cycle -> data=new value, rd_busy=1.
- Read-during-write: x3 holds 0x100, write x3=0x200 while reading x3 -> 0x100 without the macro, 0x200 with REGFILE_BYPASS_EN. Both configurations read 0x200 on the next cycle.
- Reset mid-operation: assert rst_n=0 in the same cycle as a write x4=0x77 and sb_set x4 -> x4=0 and rd_busy=0 after reset release.
